// File: rtl/addsub_serial.sv
// Purpose: digit-serial WIDTH-bit adder/subtractor, CHUNK bits per clock via a registered carry; optional ADDSUB_OVF_EN enables signed overflow (else ovf tied 0).
// Latency: N+1 cycles from accepted start to the done pulse, where N = WIDTH/CHUNK.
// Backpressure: start is honoured only in IDLE or DONE; a start during RUN is dropped, with no queuing.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             O,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  int               base;
  logic             accept;
  logic             last;

  // Slice the current chunk out of both operands and add it with the running carry.
  always_comb begin
    base      = int'(k) * CHUNK;
    a_chunk   = op_a[base +: CHUNK];
    b_chunk   = op_b[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    accept    = start && (state == IDLE || state == DONE);
    last      = (state == RUN) && (k == K_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs; DONE may restart directly for back-to-back use.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one chunk of sum and carry per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      k     <= '0;
      S     <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with O.
      op_a  <= A;
      op_b  <= B ^ {WIDTH{O}};
      carry <= O;
      k     <= '0;
      S     <= '0;
    end else if (state == RUN) begin
      S[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry            <= chunk_sum[CHUNK];
      // Counter holds at the last chunk rather than wrapping.
      if (!last) k <= k + 1'b1;
      if (last)  cout <= chunk_sum[CHUNK];
    end
  end

`ifdef ADDSUB_OVF_EN
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  always_comb begin
    msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk_sum[CHUNK-1];
  end

  // Signed overflow registered alongside cout on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= msb_cin ^ chunk_sum[CHUNK];
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Purpose: self-checking bench for addsub_serial with WIDTH=8, CHUNK=2 (N=4).
// Latency: expects done 5 cycles after the start edge and busy for 4 cycles.
// Backpressure: covers start ignored during RUN and start held high continuously.
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       O = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       busy, done, cout, ovf;
  logic [7:0] S;

  int errors = 0;
  int checks = 0;

  addsub_serial #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .O(O), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       o;
    logic [7:0] s;
    logic       c, v;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // The overflow flag only exists when the feature macro is defined.
  function automatic logic ovf_exp(input logic v);
`ifdef ADDSUB_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Launches one operation and waits for done; lat=0 means done never arrived.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic o,
                        output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; O = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic op_check(input string tag, input vec_t v);
    int lat, bcnt;
    run_op(v.a, v.b, v.o, lat, bcnt);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_S"}, S, v.s);
    check({tag, "_cout"}, cout, v.c);
    check({tag, "_ovf"}, ovf, ovf_exp(v.v));
  endtask

  vec_t dir[5];
  logic [7:0] sweep_b[5];
  logic [7:0] sweep_a[2];

  initial begin
    int lat, bcnt, t;
    vec_t v;
    logic [7:0] bb;
    logic [8:0] sum;

    // Reset state.
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Add with latency and busy-width checks.
    run_op(8'd5, 8'd3, 1'b0, lat, bcnt);
    check("add_lat", lat, 5);
    check("add_busy_cycles", bcnt, 4);
    check("add_done_busy", busy, 0);
    check("add_S", S, 8'h08);
    check("add_cout", cout, 0);
    check("add_ovf", ovf, 0);
    @(negedge clk);
    check("add_done_pulse", done, 0);
    check("add_S_held", S, 8'h08);

    // Directed subtract and overflow vectors.
    dir[0] = '{a: 8'h05, b: 8'h03, o: 1'b1, s: 8'h02, c: 1'b1, v: 1'b0};
    dir[1] = '{a: 8'h03, b: 8'h05, o: 1'b1, s: 8'hFE, c: 1'b0, v: 1'b0};
    dir[2] = '{a: 8'h7F, b: 8'h01, o: 1'b0, s: 8'h80, c: 1'b0, v: 1'b1};
    dir[3] = '{a: 8'h80, b: 8'h01, o: 1'b1, s: 8'h7F, c: 1'b1, v: 1'b1};
    dir[4] = '{a: 8'hFF, b: 8'h01, o: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0};
    for (int i = 0; i < 5; i++) op_check($sformatf("dir%0d", i), dir[i]);

    // Corner sweep against a plain full-width reference.
    sweep_b = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    sweep_a = '{8'h00, 8'hFF};
    for (int o = 0; o < 2; o++)
      for (int bi = 0; bi < 5; bi++)
        for (int ai = 0; ai < 2; ai++) begin
          bb  = (o != 0) ? ~sweep_b[bi] : sweep_b[bi];
          sum = {1'b0, sweep_a[ai]} + {1'b0, bb} + 9'(o);
          v.a = sweep_a[ai];
          v.b = sweep_b[bi];
          v.o = (o != 0);
          v.s = sum[7:0];
          v.c = sum[8];
          v.v = (sweep_a[ai][7] == bb[7]) && (sum[7] != sweep_a[ai][7]);
          op_check($sformatf("swp_o%0d_a%02h_b%02h", o, v.a, v.b), v);
        end

    // Start pulsed during RUN is ignored.
    @(negedge clk);
    A = 8'd5; B = 8'd3; O = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'd1; B = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ign_done", done, 1);
    check("ign_S", S, 8'h08);
    @(negedge clk);
    check("ign_idle_busy", busy, 0);
    check("ign_idle_done", done, 0);

    // Start held high: done every 5 cycles.
    A = 8'd5; B = 8'd3; O = 1'b0; start = 1'b1;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done", done, 1);
    for (int p = 0; p < 2; p++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 20);
      check($sformatf("b2b_gap%0d", p), t, 5);
      check($sformatf("b2b_S%0d", p), S, 8'h08);
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop_busy", busy, 0);

    // Reset mid-operation clears everything immediately.
    A = 8'hFF; B = 8'h00; O = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_S", S, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd2, 8'd2, 1'b0, lat, bcnt);
    check("post_rst_lat", lat, 5);
    check("post_rst_S", S, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor. It is the sequential successor to the fixed 3-bit selective 2's-complement stage. The block latches two WIDTH-bit operands and a mode bit, conditionally complements B, and resolves the sum CHUNK bits per clock through a registered carry. It reports result, carry-out and signed overflow with a start/busy/done handshake, and sits in the datapath wherever a small-area add/sub is preferred over a full-width ripple adder.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- CHUNK, 2, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only while idle.
- O  in  1  mode: 0 = A+B, 1 = A−B (B selectively 2's-complemented).
- A  in  WIDTH  operand A, sampled with start.
- B  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when S/cout/ovf become valid.
- S  out  WIDTH  result, held until the next accepted start.
- cout  out  1  carry out of the MSB; in subtract mode 1 = no borrow.
- ovf  out  1  signed 2's-complement overflow (see Configuration).

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE → RUN on start=1. On that edge the block latches A into opA, latches (B XOR {WIDTH{O}}) into opB, sets carry = O, clears chunk counter k to 0, and clears S.
- RUN: each edge adds opA[k*CHUNK +: CHUNK] + opB[k*CHUNK +: CHUNK] + carry.
  - The CHUNK-bit sum is written into S[k*CHUNK +: CHUNK].
  - The carry register takes the chunk carry-out.
  - k increments.
- RUN → DONE on the edge that processes chunk N−1. That edge sets cout to the final carry and sets ovf to the carry into the MSB XOR the carry out of the MSB.
- DONE lasts one cycle, then goes → IDLE. A start sampled in DONE is accepted as if in IDLE (back-to-back).
- start while in RUN is ignored. No queuing; operands and O are not re-sampled.
- Arithmetic is modulo 2^WIDTH; there is no saturation. O=1 with B=0 gives S=A and cout=1.
- The k counter width is $clog2(N), minimum 1. The counter never wraps past N−1.
- Reset asserted at any time, including mid-RUN: the operation is aborted and all state is cleared immediately (asynchronous). After rst_n deasserts, the first start is accepted normally.

## Timing
- Reset values: busy=0, done=0, S=0, cout=0, ovf=0, FSM=IDLE, k=0, carry=0.
- start is accepted at edge T. busy=1 from T until the edge that enters DONE. Chunks are processed at edges T+1 … T+N.
- done=1 for exactly the cycle after edge T+N, and busy=0 in that cycle. Latency from start edge to done is N+1 cycles.
- S, cout and ovf are stable from done onward until the next accepted start clears S. Intermediate S bits are visible during RUN and are not valid until done.
- Maximum throughput is one operation per N+1 cycles, with start held high continuously.

## Configuration
- ADDSUB_OVF_EN
  - Defined: the ovf output is computed as above and registered with cout.
  - Undefined: the overflow logic is removed and ovf is tied to 0. All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 (N=4) and ADDSUB_OVF_EN defined unless noted.
- Add: A=5, B=3, O=0 → done at start+5 cycles, S=0x08, cout=0, ovf=0; busy high for exactly 4 cycles.
- Subtract without borrow / with borrow:
  - A=5, B=3, O=1 → S=0x02, cout=1, ovf=0.
  - A=3, B=5, O=1 → S=0xFE, cout=0, ovf=0.
- Overflow:
  - A=0x7F, B=0x01, O=0 → S=0x80, ovf=1, cout=0.
  - A=0x80, B=0x01, O=1 → S=0x7F, ovf=1, cout=1.
  - With ADDSUB_OVF_EN undefined, ovf=0 for both.
- Exhaustive corner sweep: O∈{0,1} × B∈{0x00,0x01,0x7F,0x80,0xFF} × A∈{0x00,0xFF} → S, cout and ovf match the reference model. Includes A=0xFF, B=0x01, O=0 → S=0x00, cout=1.
- Handshake:
  - A second start with A=1, B=1 pulsed during RUN is ignored and the first result is unchanged.
  - start held high → back-to-back results with done pulses every 5 cycles.
- Reset mid-op: assert rst_n=0 two cycles after start → busy, done, S, cout and ovf go to 0 immediately. After release, a new start with A=2, B=2, O=0 yields S=0x04.
